// File: rtl/usb_frame_pkg.sv
// Shared definitions for the USB frame arbiter: state encoding, default sync
// word and descriptor field widths. Optional trailer: USB_FRAME_SUM_EN.
package usb_frame_pkg;

  localparam logic [5:0] ST_IDLE_ENC    = 6'b000001;
  localparam logic [5:0] ST_SYNC_ENC    = 6'b000010;
  localparam logic [5:0] ST_DESC_ENC    = 6'b000100;
  localparam logic [5:0] ST_PAYLOAD_ENC = 6'b001000;
  localparam logic [5:0] ST_TRAIL_ENC   = 6'b010000;
  localparam logic [5:0] ST_DONE_ENC    = 6'b100000;

  typedef enum logic [5:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_SYNC_W  = ST_SYNC_ENC,
    ST_DESC_W  = ST_DESC_ENC,
    ST_PAYLOAD = ST_PAYLOAD_ENC,
    ST_TRAIL   = ST_TRAIL_ENC,
    ST_DONE    = ST_DONE_ENC
  } state_t;

  localparam logic [15:0] SYNC_DEFAULT = 16'hAA55;

  // Descriptor layout: {channel id, payload length}
  localparam int CHW      = 4;
  localparam int LENW_DEF = 12;

endpackage

// File: rtl/usb_frame_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the
// pointer, wrapping modulo N. Reusable by any multi-source path.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int c;

  // Scan from the farthest offset down so the closest requester wins last
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = IW'(c);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_frame_arbiter.sv
// Round-robin arbiter and framer feeding the USB streaming write port.
// Each grant emits SYNC, descriptor {chan, len}, then len payload words,
// honouring i_full word by word. Define USB_FRAME_SUM_EN to append a
// 16-bit payload-sum trailer word to every frame.
module usb_frame_arbiter
  import usb_frame_pkg::*;
#(
  parameter int             NCH  = 2,
  parameter int             DW   = 16,
  parameter int             LENW = LENW_DEF,
  parameter logic [DW-1:0]  SYNC = DW'(SYNC_DEFAULT)
) (
  input  logic                i_clk_sys,
  input  logic                i_rst_n,
  input  logic [NCH-1:0]      i_req,
  input  logic [NCH*LENW-1:0] i_len,
  input  logic [NCH*DW-1:0]   i_data,
  output logic [NCH-1:0]      o_gnt,
  output logic [NCH-1:0]      o_rd,
  output logic                o_wr,
  output logic [DW-1:0]       o_data,
  input  logic                i_full,
  output logic                o_busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

`ifdef USB_FRAME_SUM_EN
  localparam state_t POST_PAYLOAD = ST_TRAIL;
`else
  localparam state_t POST_PAYLOAD = ST_DONE;
`endif

  state_t          state_q, state_d;
  logic [NCH-1:0]  gnt_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   ptr_q;
  logic [LENW-1:0] len_q;
  logic [LENW-1:0] cnt_q;
  logic [NCH-1:0]  pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic            emitting;
  logic            grant_now;

  rr_pick #(.N(NCH), .IW(IW)) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign emitting  = (state_q == ST_SYNC_W) || (state_q == ST_DESC_W) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_TRAIL);
  assign o_wr      = emitting & ~i_full;
  assign grant_now = (state_q == ST_IDLE) && pick_valid;
  assign o_gnt     = gnt_q;
  assign o_busy    = (state_q != ST_IDLE);

`ifdef USB_FRAME_SUM_EN
  logic [15:0] sum_q;

  // Payload checksum: cleared at grant, accumulates every written payload word
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n)                          sum_q <= '0;
    else if (grant_now)                    sum_q <= '0;
    else if (state_q == ST_PAYLOAD && o_wr) sum_q <= sum_q + 16'(o_data);
  end
`endif

  // State register
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Per-frame registers: grant, channel, length, word counter, RR pointer
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      if (grant_now) begin
        gnt_q <= pick_gnt;
        idx_q <= pick_idx;
        len_q <= i_len[pick_idx*LENW +: LENW];
        cnt_q <= '0;
      end
      if (state_q == ST_PAYLOAD && o_wr) cnt_q <= cnt_q + LENW'(1);
      if (state_q == ST_DONE) begin
        gnt_q <= '0;
        ptr_q <= (idx_q == IW'(NCH - 1)) ? '0 : idx_q + IW'(1);
      end
    end
  end

  // Next state and emitted word; progress only on cycles that actually write
  always_comb begin
    state_d = state_q;
    o_data  = '0;
    o_rd    = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_SYNC_W;
      end
      ST_SYNC_W: begin
        o_data = SYNC;
        if (o_wr) state_d = ST_DESC_W;
      end
      ST_DESC_W: begin
        o_data = DW'({CHW'(idx_q), len_q});
        if (o_wr) state_d = (len_q == '0) ? POST_PAYLOAD : ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        o_data = i_data[idx_q*DW +: DW];
        o_rd   = o_wr ? gnt_q : '0;
        if (o_wr && cnt_q == len_q - LENW'(1)) state_d = POST_PAYLOAD;
      end
`ifdef USB_FRAME_SUM_EN
      ST_TRAIL: begin
        o_data = DW'(sum_q);
        if (o_wr) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/usb_frame_arbiter.md
Name: usb_frame_arbiter

Overview:
- Round-robin arbiter and framer between NCH acquisition channels and the single USB streaming write port, i.e. the write side of the usb block (i_wr/i_data/o_full), in the system clock domain.
- Grants one channel at a time and emits one complete frame for it: sync word, descriptor word, then payload.
- Obeys FIFO full back-pressure word by word.
- Keeps frames contiguous so the host can re-synchronise on the sync word.

Parameters:
- NCH, 2, number of requesting channels (1..16).
- DW, 16, data word width; must equal the USB FIFO width.
- LENW, 12, payload length field width in words (max 4095).
- SYNC, 16'hAA55, frame sync word.

Ports:
- i_clk_sys  in  1  system clock; also the USB FIFO write clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  NCH  per-channel request; a frame is ready; level, held until granted.
- i_len  in  NCH*LENW  per-channel payload word count; channel k occupies bits [k*LENW +: LENW].
- i_data  in  NCH*DW  per-channel show-ahead payload word; channel k occupies bits [k*DW +: DW].
- o_gnt  out  NCH  one-hot grant, held for the whole frame.
- o_rd  out  NCH  per-channel pop strobe; the word on i_data is consumed in the cycle o_rd is high.
- o_wr  out  1  write strobe to the USB FIFO (drives usb i_wr).
- o_data  out  DW  write data to the USB FIFO (drives usb i_data).
- i_full  in  1  USB FIFO full (from usb o_full).
- o_busy  out  1  a frame is in progress (state != IDLE).

Behaviour:
- Clock and reset: single clock i_clk_sys; asynchronous active-low reset i_rst_n.
- Reset values: state IDLE; o_gnt 0; RR pointer 0; word counter 0; o_wr 0; o_rd 0; o_busy 0; o_data 0.
- States: IDLE, SYNC_W, DESC_W, PAYLOAD, TRAIL (only with the option), DONE.
- IDLE:
  - If any i_req bit is set, pick the first requester at or after the RR pointer, wrapping modulo NCH.
  - Register the one-hot o_gnt and latch that channel's i_len into len_q.
  - Next state is SYNC_W. Grant latency is 1 cycle from the request being seen.
- Emit rule, applies to SYNC_W, DESC_W, PAYLOAD and TRAIL:
  - o_wr = emitting & !i_full, combinational.
  - The state or counter advances only on a cycle where o_wr = 1.
  - No write is ever issued while i_full = 1.
- SYNC_W: o_data = SYNC. Next state is DESC_W.
- DESC_W: o_data = {4'(channel index), len_q}. Next state is PAYLOAD, or straight to DONE (or TRAIL) when len_q == 0.
- PAYLOAD:
  - o_data = i_data of the granted channel.
  - o_rd[granted] = o_wr, so exactly one pop per written word.
  - The word counter increments on each write. After the len_q-th write, go to DONE (or TRAIL).
- DONE:
  - Clear o_gnt and set the RR pointer to granted index + 1 (mod NCH).
  - Return to IDLE. Inter-frame gap is at least 2 cycles (DONE + IDLE).
- i_req changes during a frame are ignored. i_len is sampled only at grant.
- If i_full is held high, the block stalls indefinitely with its outputs stable. There is no timeout.
- The channel must keep valid data on i_data for len_q words. An underrun is the source's fault and is not detected.
- Reset mid-frame aborts at once, and the partial frame is left in the FIFO. The host discards it by re-syncing on SYNC.
- Maximum throughput is 1 word per cycle with i_full low. Frame cost is len + 2 words (len + 3 with the option).

Optional Feature:
- Macro: USB_FRAME_SUM_EN.
- Defined:
  - TRAIL state appended after the payload, or after DESC_W when len = 0.
  - TRAIL writes a 16-bit sum, mod 2^16, of all payload words of the frame. The accumulator clears at grant and adds on each payload write.
  - Same back-pressure rule as the other emit states. The descriptor length field is unchanged (payload only).
- Undefined: no TRAIL state, no accumulator. A frame is exactly len + 2 words.

Decomposition:
- Package usb_frame_pkg:
  - state encoding localparams (one-hot, 6 bits)
  - SYNC default
  - descriptor field widths (4-bit channel id, LENW length)
- Sub-module rr_pick: combinational round-robin priority selector. Inputs are the req vector and the pointer; outputs are the one-hot grant and the index. Reusable by other multi-source paths.

Test Plan:
- NCH=2, ch0 req with len=3, data 0x0001..0x0003, i_full=0 → o_data sequence 0xAA55, 0x0003, 0x0001, 0x0002, 0x0003 on 5 consecutive o_wr; o_rd[0] high exactly 3 cycles.
- Both channels requesting continuously with len=2 → frames alternate ch0, ch1, ch0; descriptors 0x0002, 0x1002, 0x0002.
- i_full forced high for 4 cycles mid-payload → o_wr and o_rd stay low for those 4 cycles, no word dropped or duplicated, output sequence identical to the unstalled run.
- ch1 with len=0 → exactly 2 writes (0xAA55, 0x1000) and no o_rd. With USB_FRAME_SUM_EN, a third write of 0x0000.
- USB_FRAME_SUM_EN, len=2, data 0xFFFF, 0x0003 → trailer 0x0002 (wrap-around).
- i_rst_n pulsed low in PAYLOAD → o_wr, o_gnt and o_busy go 0 immediately. After release, the next frame starts with 0xAA55 and the RR pointer is 0.
